pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush inputs
//  of the fetch/decode and decode/execute intermediate registers, plus the PC write and PC

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/load_use_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: PC source selects,
// FSM state encoding and the default register-index width.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W_DEF = 3;

    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_VECTOR = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_INT_DRAIN  = 2'd1,
        ST_INT_VECTOR = 2'd2
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Purely combinational load-use compare between the decode-stage sources
// and the destination of a load currently in EX.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] Rs_decode,
    input  logic [REG_W-1:0] Rd_decode,
    input  logic             uses_rs,
    input  logic             uses_rd,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             lu
);

    assign lu = ex_mem_read & ((uses_rs & (Rs_decode == ex_rd)) |
                               (uses_rd & (Rd_decode == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, taken-branch flushes and
// interrupt entry (drain the pipe, then redirect to the vector).
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs_decode,
    input  logic [REG_W-1:0] Rd_decode,
    input  logic             uses_rs,
    input  logic             uses_rd,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             int_req,
    output logic             en_fd,
    output logic             en_de,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             int_ack,
    output logic             busy_int,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hz_state_t         state, next_state;
    logic              int_pending;
    logic [DW-1:0]     drain_cnt;
    logic              lu;

    load_use_detect #(.REG_W(REG_W)) u_lu (
        .Rs_decode   (Rs_decode),
        .Rd_decode   (Rd_decode),
        .uses_rs     (uses_rs),
        .uses_rd     (uses_rd),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .lu          (lu)
    );

    always_comb begin
        next_state = state;
        en_fd      = 1'b1;
        en_de      = 1'b1;
        flush_fd   = 1'b0;
        flush_de   = 1'b0;
        pc_write   = 1'b1;
        pc_sel     = PC_SEL_SEQ;
        int_ack    = 1'b0;
        // While in reset the outputs hold the plain RUN values.
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (branch_taken) begin
                        flush_fd = 1'b1;
                        flush_de = 1'b1;
                        pc_sel   = PC_SEL_BRANCH;
                    end else if (lu) begin
                        en_fd    = 1'b0;
                        pc_write = 1'b0;
                        flush_de = 1'b1;
                    end else if (int_pending) begin
                        next_state = ST_INT_DRAIN;
                    end
                end
                ST_INT_DRAIN: begin
                    pc_write = 1'b0;
                    flush_fd = 1'b1;
                    // A branch resolved while draining is dropped; EX keeps its return address.
                    flush_de = branch_taken;
                    if (drain_cnt == '0) next_state = ST_INT_VECTOR;
                end
                ST_INT_VECTOR: begin
                    pc_sel     = PC_SEL_VECTOR;
                    flush_fd   = 1'b1;
                    int_ack    = 1'b1;
                    next_state = ST_RUN;
                end
                default: next_state = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            int_pending <= 1'b0;
            drain_cnt   <= '0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            if (state == ST_RUN && int_req)
                int_pending <= 1'b1;
            else if (state == ST_INT_VECTOR)
                int_pending <= 1'b0;
            if (state == ST_RUN && next_state == ST_INT_DRAIN)
                drain_cnt <= DW'(DRAIN_CYCLES - 1);
            else if (state == ST_INT_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
            if (state == ST_RUN && lu && !branch_taken && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

    assign busy_int = (state != ST_RUN);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (DRAIN_CYCLES=3, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] Rs_decode, Rd_decode, ex_rd;
    logic       uses_rs, uses_rd, ex_mem_read, branch_taken, int_req;
    logic       en_fd, en_de, flush_fd, flush_de, pc_write, int_ack, busy_int;
    logic [1:0] pc_sel;
    logic [3:0] stall_count;

    int checks = 0;
    int errors = 0;
    int acks;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(3), .DRAIN_CYCLES(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .Rs_decode(Rs_decode), .Rd_decode(Rd_decode),
        .uses_rs(uses_rs), .uses_rd(uses_rd),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .int_req(int_req),
        .en_fd(en_fd), .en_de(en_de), .flush_fd(flush_fd), .flush_de(flush_de),
        .pc_write(pc_write), .pc_sel(pc_sel), .int_ack(int_ack),
        .busy_int(busy_int), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs_decode = 0; Rd_decode = 0; ex_rd = 0;
        uses_rs = 0; uses_rd = 0; ex_mem_read = 0;
        branch_taken = 0; int_req = 0;
    endtask

    // Packs {en_fd, en_de, flush_fd, flush_de, pc_write, pc_sel, int_ack, busy_int}
    function automatic logic [8:0] ctl();
        return {en_fd, en_de, flush_fd, flush_de, pc_write, pc_sel, int_ack, busy_int};
    endfunction

    localparam logic [8:0] C_RUN    = 9'b1_1_0_0_1_00_0_0;
    localparam logic [8:0] C_LU     = 9'b0_1_0_1_0_00_0_0;
    localparam logic [8:0] C_BR     = 9'b1_1_1_1_1_01_0_0;
    localparam logic [8:0] C_DRAIN  = 9'b1_1_1_0_0_00_0_1;
    localparam logic [8:0] C_DRBR   = 9'b1_1_1_1_0_00_0_1;
    localparam logic [8:0] C_VECTOR = 9'b1_1_1_0_1_10_1_1;

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        chk("reset_ctl", ctl(), C_RUN);
        chk("reset_cnt", stall_count, 4'd0);
        rst = 1'b0;
        #3 chk("idle_ctl", ctl(), C_RUN);

        // load-use on Rs
        ex_mem_read = 1; ex_rd = 3; Rs_decode = 3; uses_rs = 1;
        #3 chk("lu_rs_ctl", ctl(), C_LU);
        tick();
        uses_rs = 0;
        chk("lu_rs_cnt", stall_count, 4'd1);
        #3 chk("no_use_ctl", ctl(), C_RUN);
        tick();
        chk("no_use_cnt", stall_count, 4'd1);

        // load-use on Rd, then register mismatch
        uses_rd = 1; Rd_decode = 3;
        #3 chk("lu_rd_ctl", ctl(), C_LU);
        tick();
        chk("lu_rd_cnt", stall_count, 4'd2);
        ex_rd = 4;
        #3 chk("reg_miss_ctl", ctl(), C_RUN);

        // branch overrides load-use
        ex_rd = 3; branch_taken = 1;
        #3 chk("br_lu_ctl", ctl(), C_BR);
        tick();
        idle_inputs();
        chk("br_lu_cnt", stall_count, 4'd2);

        // interrupt pulse: 1 RUN, 3 DRAIN (branch in the middle one), VECTOR, RUN
        int_req = 1;
        #3 chk("int_req_ctl", ctl(), C_RUN);
        tick();
        int_req = 0;
        #3 chk("int_run_ctl", ctl(), C_RUN);
        tick();
        #3 chk("drain1_ctl", ctl(), C_DRAIN);
        tick();
        branch_taken = 1;
        #3 chk("drain2_br_ctl", ctl(), C_DRBR);
        tick();
        branch_taken = 0;
        #3 chk("drain3_ctl", ctl(), C_DRAIN);
        tick();
        #3 chk("vector_ctl", ctl(), C_VECTOR);
        tick();
        #3 chk("post_vec_ctl", ctl(), C_RUN);

        // int_req held until ack -> exactly one ack in 10 cycles
        acks = 0;
        int_req = 1;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (int_ack) acks++;
            tick();
            if (acks != 0) int_req = 0;
        end
        chk("held_acks", acks, 1);
        chk("held_busy", busy_int, 1'b0);

        // reset during the second drain cycle drops the interrupt
        int_req = 1;
        tick();
        int_req = 0;
        tick();
        tick();
        #3 chk("rst_drain_busy", busy_int, 1'b1);
        rst = 1;
        #1 chk("rst_high_ctl", {en_fd, en_de, flush_fd, flush_de, pc_write, pc_sel, int_ack},
               {C_RUN[8:2], 1'b0});
        tick();
        rst = 0;
        chk("rst_drain_busy0", busy_int, 1'b0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            #3;
            if (int_ack || busy_int) acks++;
            tick();
        end
        chk("rst_drain_noack", acks, 0);

        // saturation of the 4-bit stall counter
        ex_mem_read = 1; ex_rd = 5; Rs_decode = 5; uses_rs = 1;
        for (int i = 0; i < 12; i++) tick();
        chk("sat_mid", stall_count, 4'd12);
        for (int i = 0; i < 8; i++) tick();
        chk("sat_cnt", stall_count, 4'd15);
        #3 chk("sat_ctl", ctl(), C_LU);
        idle_inputs();
        tick();
        chk("sat_hold", stall_count, 4'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
